// File: rtl/pipe_skid_stage.sv
// ============================================================================
// pipe_skid_stage
//   Elastic pipeline-stage register: valid/ready handshake, 2-entry skid
//   buffer, flush, and saturating stall/bubble counters.
//   Revision: 1.0
// ============================================================================
`default_nettype none

module pipe_skid_stage #(
    parameter int DATA_W = 136,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  bubble_cnt
);

    localparam logic [1:0] c_empty = 2'd0;
    localparam logic [1:0] c_one   = 2'd1;
    localparam logic [1:0] c_full  = 2'd2;

    logic [1:0]        r_state;
    logic [1:0]        w_next_state;
    logic [DATA_W-1:0] r_main;
    logic [DATA_W-1:0] r_skid;
    logic [CNT_W-1:0]  r_stall_cnt;
    logic [CNT_W-1:0]  r_bubble_cnt;

    logic w_in_fire;
    logic w_out_fire;
    logic w_load_main_in;
    logic w_load_main_skid;
    logic w_load_skid;

    assign w_in_fire  = in_valid & in_ready;
    assign w_out_fire = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= c_empty;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_empty: if (w_in_fire) w_next_state = c_one;
            c_one: begin
                if (w_in_fire && !w_out_fire)      w_next_state = c_full;
                else if (!w_in_fire && w_out_fire) w_next_state = c_empty;
            end
            c_full:  if (w_out_fire) w_next_state = c_one;
            default: w_next_state = c_empty;
        endcase
        // Flush squashes every held and in-flight entry.
        if (flush) w_next_state = c_empty;
    end

    // in_ready and out_valid come straight from state flops: no combinational
    // path from out_ready back to upstream.
    always_comb begin
        out_valid = 1'b0;
        in_ready  = 1'b1;
        occupancy = 2'd0;
        case (r_state)
            c_one: begin
                out_valid = 1'b1;
                occupancy = 2'd1;
            end
            c_full: begin
                out_valid = 1'b1;
                in_ready  = 1'b0;
                occupancy = 2'd2;
            end
            default: ;
        endcase
    end

    // Flush only clears valids; payload registers retain their contents.
    assign w_load_main_in   = !flush && w_in_fire &&
                              ((r_state == c_empty) || ((r_state == c_one) && w_out_fire));
    assign w_load_skid      = !flush && w_in_fire && (r_state == c_one) && !w_out_fire;
    assign w_load_main_skid = !flush && w_out_fire && (r_state == c_full);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_main <= '0;
            r_skid <= '0;
        end else begin
            if (w_load_main_in) begin
                r_main <= in_data;
            end else if (w_load_main_skid) begin
                r_main <= r_skid;
            end
            if (w_load_skid) begin
                r_skid <= in_data;
            end
        end
    end

    assign out_data = r_main;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_stall_cnt  <= '0;
            r_bubble_cnt <= '0;
        end else begin
            if (out_valid && !out_ready && (r_stall_cnt != {CNT_W{1'b1}})) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
            if (!out_valid && out_ready && (r_bubble_cnt != {CNT_W{1'b1}})) begin
                r_bubble_cnt <= r_bubble_cnt + CNT_W'(1);
            end
        end
    end

    assign stall_cnt  = r_stall_cnt;
    assign bubble_cnt = r_bubble_cnt;

endmodule

`default_nettype wire
